// File: rtl/stream_compare_checker.sv
// stream_compare_checker
//   Compares a received AXI4-Stream beat-by-beat against an expected stream.
//   The expected stream is either an external AXI4-Stream (mode 0) or an
//   internal seeded Galois-LFSR generator (mode 1). Results go to status
//   outputs: pass/fail, saturating mismatch count, length error and a capture
//   of the first mismatching beat.
// Ports:
//   ap_clk, ap_rst_n          kernel clock, synchronous active-low reset
//   cfg_start/mode/seed/len   run configuration, sampled on cfg_start
//   s_dut_*                   received stream (tvalid/tready/tdata/tkeep/tlast)
//   s_exp_*                   external expected stream (tvalid/tready/tdata)
//   busy, done, pass          run status
//   err_count, len_err        mismatching beat count, tlast position error
//   first_err_beat/dut/exp    capture of the first mismatching beat
module stream_compare_checker #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned LEN_W  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                cfg_start,
  input  logic                cfg_mode,
  input  logic [31:0]         cfg_seed,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                s_dut_tvalid,
  output logic                s_dut_tready,
  input  logic [DATA_W-1:0]   s_dut_tdata,
  input  logic [DATA_W/8-1:0] s_dut_tkeep,
  input  logic                s_dut_tlast,
  input  logic                s_exp_tvalid,
  output logic                s_exp_tready,
  input  logic [DATA_W-1:0]   s_exp_tdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    err_count,
  output logic                len_err,
  output logic [LEN_W-1:0]    first_err_beat,
  output logic [DATA_W-1:0]   first_err_dut,
  output logic [DATA_W-1:0]   first_err_exp
);

  localparam int unsigned  BYTES     = DATA_W / 8;
  localparam int unsigned  LANES     = DATA_W / 32;
  localparam logic [31:0]  LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0]  LANE_STEP = 32'h9E37_79B9;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic                len_err_q, len_err_d;
  logic [LEN_W-1:0]    first_err_beat_q, first_err_beat_d;
  logic [DATA_W-1:0]   first_err_dut_q, first_err_dut_d;
  logic [DATA_W-1:0]   first_err_exp_q, first_err_exp_d;

  logic [DATA_W-1:0]   prng_data;
  logic [DATA_W-1:0]   exp_data;
  logic [BYTES-1:0]    byte_diff;
  logic [31:0]         lfsr_next;
  logic                run;
  logic                fire;
  logic                mismatch;
  logic                last_beat;

  // Expected-beat generation, byte-masked compare and join handshake
  always_comb begin
    prng_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prng_data[i*32 +: 32] = lfsr_q ^ 32'(i * LANE_STEP);
    end
    exp_data = mode_q ? prng_data : s_exp_tdata;

    byte_diff = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      byte_diff[b] = s_dut_tkeep[b] && (s_dut_tdata[b*8 +: 8] != exp_data[b*8 +: 8]);
    end
    mismatch = |byte_diff;

    lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

    run          = (state_q == ST_RUN);
    // Each ready mirrors the other side's valid so neither stream moves alone
    s_dut_tready = run && (mode_q || s_exp_tvalid);
    s_exp_tready = run && !mode_q && s_dut_tvalid;
    fire         = run && s_dut_tvalid && (mode_q || s_exp_tvalid);
    last_beat    = (beat_q == (len_q - LEN_W'(1)));
  end

  // Next-state and status update
  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    len_d            = len_q;
    beat_d           = beat_q;
    lfsr_d           = lfsr_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    len_err_d        = len_err_q;
    first_err_beat_d = first_err_beat_q;
    first_err_dut_d  = first_err_dut_q;
    first_err_exp_d  = first_err_exp_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_start) begin
          state_d          = ST_RUN;
          mode_d           = cfg_mode;
          len_d            = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
          lfsr_d           = (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
          beat_d           = '0;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          err_count_d      = '0;
          len_err_d        = 1'b0;
          first_err_beat_d = '0;
          first_err_dut_d  = '0;
          first_err_exp_d  = '0;
        end
      end
      ST_RUN: begin
        if (fire) begin
          beat_d = beat_q + LEN_W'(1);
          lfsr_d = lfsr_next;
          if (mismatch) begin
            // err_count is still zero only until the first mismatch of the run
            if (err_count_q == '0) begin
              first_err_beat_d = beat_q;
              first_err_dut_d  = s_dut_tdata;
              first_err_exp_d  = exp_data;
            end
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
          end
          if (s_dut_tlast != last_beat) begin
            len_err_d = 1'b1;
          end
          // Early tlast also terminates the run
          if (last_beat || s_dut_tlast) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0) && !len_err_d;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q          <= ST_IDLE;
      mode_q           <= 1'b0;
      len_q            <= '0;
      beat_q           <= '0;
      lfsr_q           <= 32'h1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      len_err_q        <= 1'b0;
      first_err_beat_q <= '0;
      first_err_dut_q  <= '0;
      first_err_exp_q  <= '0;
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      len_q            <= len_d;
      beat_q           <= beat_d;
      lfsr_q           <= lfsr_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      len_err_q        <= len_err_d;
      first_err_beat_q <= first_err_beat_d;
      first_err_dut_q  <= first_err_dut_d;
      first_err_exp_q  <= first_err_exp_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign len_err        = len_err_q;
  assign first_err_beat = first_err_beat_q;
  assign first_err_dut  = first_err_dut_q;
  assign first_err_exp  = first_err_exp_q;

endmodule

// File: tb/tb_stream_compare_checker.sv
// Bench for stream_compare_checker (DATA_W=64, CNT_W=2): directed runs with a
// behavioural reference model checked every cycle plus literal expectations.
module tb_stream_compare_checker;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned CNT_W  = 2;
  localparam int          ERR_MAX = 3;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              cfg_start, cfg_mode;
  logic [31:0]       cfg_seed;
  logic [LEN_W-1:0]  cfg_len;
  logic              s_dut_tvalid, s_dut_tready, s_dut_tlast;
  logic [DATA_W-1:0] s_dut_tdata;
  logic [7:0]        s_dut_tkeep;
  logic              s_exp_tvalid, s_exp_tready;
  logic [DATA_W-1:0] s_exp_tdata;
  logic              busy, done, pass, len_err;
  logic [CNT_W-1:0]  err_count;
  logic [LEN_W-1:0]  first_err_beat;
  logic [DATA_W-1:0] first_err_dut, first_err_exp;

  stream_compare_checker #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed), .cfg_len(cfg_len),
    .s_dut_tvalid(s_dut_tvalid), .s_dut_tready(s_dut_tready), .s_dut_tdata(s_dut_tdata),
    .s_dut_tkeep(s_dut_tkeep), .s_dut_tlast(s_dut_tlast),
    .s_exp_tvalid(s_exp_tvalid), .s_exp_tready(s_exp_tready), .s_exp_tdata(s_exp_tdata),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .len_err(len_err),
    .first_err_beat(first_err_beat), .first_err_dut(first_err_dut), .first_err_exp(first_err_exp)
  );

  initial forever #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference generator: Galois LFSR step and 2-lane expected beat
  function automatic logic [31:0] prng_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [63:0] prng_beat(input logic [31:0] s);
    return {s ^ 32'h9E37_79B9, s};
  endfunction

  // Behavioural model: 0 idle, 1 running, 2 finished
  int          m_st;
  bit          m_mode, m_busy, m_done, m_pass, m_len_err, m_cap, m_diff, m_last;
  int unsigned m_len, m_beat;
  int          m_err;
  logic [31:0] m_lfsr, m_fbeat;
  logic [63:0] m_fdut, m_fexp, m_e;

  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      m_st = 0; m_mode = 0; m_busy = 0; m_done = 0; m_pass = 0; m_len_err = 0; m_cap = 0;
      m_len = 0; m_beat = 0; m_err = 0; m_lfsr = 32'h1; m_fbeat = 0; m_fdut = 0; m_fexp = 0;
    end else if (m_st != 1) begin
      if (cfg_start) begin
        m_st = 1; m_mode = cfg_mode; m_len = (cfg_len == 0) ? 1 : cfg_len;
        m_lfsr = (cfg_seed == 0) ? 32'h1 : cfg_seed;
        m_beat = 0; m_busy = 1; m_done = 0; m_pass = 0; m_err = 0; m_len_err = 0; m_cap = 0;
        m_fbeat = 0; m_fdut = 0; m_fexp = 0;
      end
    end else if (s_dut_tvalid && (m_mode || s_exp_tvalid)) begin
      m_e = m_mode ? prng_beat(m_lfsr) : s_exp_tdata;
      m_diff = 0;
      for (int b = 0; b < 8; b++)
        if (s_dut_tkeep[b] && (s_dut_tdata[8*b +: 8] != m_e[8*b +: 8])) m_diff = 1;
      if (m_diff) begin
        if (!m_cap) begin m_cap = 1; m_fbeat = m_beat; m_fdut = s_dut_tdata; m_fexp = m_e; end
        if (m_err < ERR_MAX) m_err++;
      end
      m_last = (m_beat == m_len - 1);
      if (s_dut_tlast != m_last) m_len_err = 1;
      if (m_last || s_dut_tlast) begin
        m_st = 2; m_busy = 0; m_done = 1; m_pass = (m_err == 0) && !m_len_err;
      end
      m_beat++;
      m_lfsr = prng_step(m_lfsr);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge ap_clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("pass", 64'(pass), 64'(m_pass));
      chk("err_count", 64'(err_count), 64'(m_err));
      chk("len_err", 64'(len_err), 64'(m_len_err));
      chk("first_err_beat", 64'(first_err_beat), 64'(m_fbeat));
      chk("first_err_dut", first_err_dut, m_fdut);
      chk("first_err_exp", first_err_exp, m_fexp);
      chk("s_dut_tready", 64'(s_dut_tready), 64'((m_st == 1) && (m_mode || s_exp_tvalid)));
      chk("s_exp_tready", 64'(s_exp_tready), 64'((m_st == 1) && !m_mode && s_dut_tvalid));
    end
  end

  task automatic tick();
    @(posedge ap_clk); #1;
  endtask

  task automatic start_run(input bit mode, input logic [31:0] seed, input logic [31:0] len);
    cfg_mode = mode; cfg_seed = seed; cfg_len = len; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input bit last, input logic [63:0] e);
    s_dut_tvalid = 1'b1; s_dut_tdata = d; s_dut_tkeep = k; s_dut_tlast = last;
    s_exp_tvalid = 1'b1; s_exp_tdata = e;
    tick();
    s_dut_tvalid = 1'b0; s_exp_tvalid = 1'b0; s_dut_tlast = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic test_prng_replay();
    logic [31:0] s = 32'h1;
    start_run(1'b1, 32'h1, 4);
    for (int k = 0; k < 4; k++) begin
      send(prng_beat(s), 8'hFF, k == 3, 64'h0);
      s = prng_step(s);
      if (k == 1) begin
        cfg_len = 2; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
      end
    end
    wait_done("t1_done");
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_err", 64'(err_count), 64'd0);
    chk("t1_len_err", 64'(len_err), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
  endtask

  task automatic test_toggle();
    int di = 0, ei = 0, cyc = 0;
    bit df, ef, lone = 0;
    start_run(1'b0, 32'h0, 6);
    while ((di < 6 || ei < 6) && cyc < 200) begin
      s_exp_tvalid = (ei < 6) && cyc[0];
      s_exp_tdata  = {2{32'(32'hA0 + ei)}};
      s_dut_tvalid = (di < 6) && ($urandom_range(0, 1) == 1);
      s_dut_tdata  = {2{32'(32'hA0 + di)}};
      s_dut_tkeep  = 8'hFF;
      s_dut_tlast  = (di == 5);
      @(negedge ap_clk);
      df = s_dut_tvalid && s_dut_tready;
      ef = s_exp_tvalid && s_exp_tready;
      if (df != ef) lone = 1;
      tick();
      if (df) di++;
      if (ef) ei++;
      cyc++;
    end
    s_dut_tvalid = 1'b0; s_exp_tvalid = 1'b0; s_dut_tlast = 1'b0;
    chk("t4_dut_fires", 64'(di), 64'd6);
    chk("t4_exp_fires", 64'(ei), 64'd6);
    chk("t4_lone_fire", 64'(lone), 64'd0);
    chk("t4_pass", 64'(pass), 64'd1);
  endtask

  initial begin
    ap_rst_n = 1'b0; cfg_start = 0; cfg_mode = 0; cfg_seed = 0; cfg_len = 0;
    s_dut_tvalid = 0; s_dut_tdata = 0; s_dut_tkeep = 0; s_dut_tlast = 0;
    s_exp_tvalid = 0; s_exp_tdata = 0;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    ap_rst_n = 1'b1;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);

    // Pin the reference generator with hand-computed values
    chk("pin_step1", 64'(prng_step(32'h1)), 64'h8020_0003);
    chk("pin_step2", 64'(prng_step(32'h8020_0003)), 64'hC030_0002);
    chk("pin_beat0", prng_beat(32'h1), 64'h9E37_79B8_0000_0001);
    chk("pin_beat1", prng_beat(32'h8020_0003), 64'h1E17_79BA_8020_0003);

    test_prng_replay();

    // External expected stream, mismatch on beat 1
    start_run(1'b0, 32'h0, 3);
    send(64'h1111_1111_1111_1111, 8'hFF, 0, 64'h1111_1111_1111_1111);
    send(64'h2222_2222_2222_2223, 8'hFF, 0, 64'h2222_2222_2222_2222);
    send(64'h3333_3333_3333_3333, 8'hFF, 1, 64'h3333_3333_3333_3333);
    wait_done("t2_done");
    chk("t2_err", 64'(err_count), 64'd1);
    chk("t2_beat", 64'(first_err_beat), 64'd1);
    chk("t2_dut", first_err_dut, 64'h2222_2222_2222_2223);
    chk("t2_exp", first_err_exp, 64'h2222_2222_2222_2222);
    chk("t2_pass", 64'(pass), 64'd0);

    // Byte 7 differs: masked, then unmasked
    start_run(1'b0, 32'h0, 1);
    send(64'hFF02_0304_0506_0708, 8'h7F, 1, 64'h0102_0304_0506_0708);
    wait_done("t3a_done");
    chk("t3a_err", 64'(err_count), 64'd0);
    chk("t3a_pass", 64'(pass), 64'd1);
    start_run(1'b0, 32'h0, 1);
    send(64'hFF02_0304_0506_0708, 8'hFF, 1, 64'h0102_0304_0506_0708);
    wait_done("t3b_done");
    chk("t3b_err", 64'(err_count), 64'd1);
    chk("t3b_pass", 64'(pass), 64'd0);

    test_toggle();

    // Early tlast, then missing tlast
    start_run(1'b0, 32'h0, 4);
    send(64'hA, 8'hFF, 0, 64'hA);
    send(64'hB, 8'hFF, 1, 64'hB);
    chk("t5a_done", 64'(done), 64'd1);
    chk("t5a_len_err", 64'(len_err), 64'd1);
    chk("t5a_pass", 64'(pass), 64'd0);
    start_run(1'b0, 32'h0, 4);
    for (int k = 0; k < 4; k++) send(64'(k), 8'hFF, 0, 64'(k));
    wait_done("t5b_done");
    chk("t5b_len_err", 64'(len_err), 64'd1);
    chk("t5b_err", 64'(err_count), 64'd0);

    // Counter saturation
    start_run(1'b0, 32'h0, 5);
    for (int k = 0; k < 5; k++) send(64'(k), 8'hFF, k == 4, ~64'(k));
    wait_done("t6_done");
    chk("t6_err_sat", 64'(err_count), 64'd3);
    chk("t6_beat", 64'(first_err_beat), 64'd0);

    // Reset mid-run
    start_run(1'b1, 32'h7, 4);
    send(64'h0, 8'hFF, 0, 64'h0);
    send(64'h0, 8'hFF, 0, 64'h0);
    chk("t7_err_pre", 64'(err_count), 64'd2);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_err", 64'(err_count), 64'd0);
    chk("t7_fdut", first_err_dut, 64'h0);
    s_dut_tvalid = 1'b1;
    @(negedge ap_clk);
    chk("t7_idle_ready", 64'(s_dut_tready), 64'd0);
    tick();
    s_dut_tvalid = 1'b0;

    // Seed 0 behaves as seed 1; len 0 behaves as len 1
    start_run(1'b1, 32'h0, 2);
    send(prng_beat(32'h1), 8'hFF, 0, 64'h0);
    send(prng_beat(32'h8020_0003), 8'hFF, 1, 64'h0);
    wait_done("t8_done");
    chk("t8_pass", 64'(pass), 64'd1);
    start_run(1'b0, 32'h0, 0);
    send(64'h55, 8'hFF, 1, 64'h55);
    wait_done("t9_done");
    chk("t9_pass", 64'(pass), 64'd1);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/stream_compare_checker.md
Name: stream_compare_checker

Overview:
- Synthesizable, parametrised successor to the simulation-only compare/random helpers.
- Checks a received AXI4-Stream (DUT output) beat-by-beat against an expected stream.
- The expected stream comes from either an external AXI4-Stream or an internal seeded pseudo-random generator.
- Sits at the kernel output in hardware self-test and co-simulation builds. Reports pass/fail, mismatch count and first-mismatch capture to host-visible status registers.

Parameters:
DATA_W, 512, stream data width in bits; multiple of 32
LEN_W, 32, width of beat-length configuration and beat counters
CNT_W, 16, width of mismatch counter (saturating)

Ports:
ap_clk  in  1  kernel clock
ap_rst_n  in  1  synchronous active-low reset
cfg_start  in  1  one-cycle pulse; starts a check run (ignored unless IDLE or DONE)
cfg_mode  in  1  0 = external expected stream, 1 = internal PRNG expected
cfg_seed  in  32  PRNG seed, sampled on cfg_start
cfg_len  in  LEN_W  expected beat count, sampled on cfg_start; 0 treated as 1
s_dut_tvalid  in  1  DUT stream valid
s_dut_tready  out  1  DUT stream ready
s_dut_tdata  in  DATA_W  DUT data
s_dut_tkeep  in  DATA_W/8  byte enables; keep=0 bytes excluded from compare
s_dut_tlast  in  1  DUT end-of-packet
s_exp_tvalid  in  1  expected stream valid (mode 0 only)
s_exp_tready  out  1  expected stream ready
s_exp_tdata  in  DATA_W  expected data
busy  out  1  high in RUN
done  out  1  high in DONE until next cfg_start
pass  out  1  valid when done: no mismatch and no length error
err_count  out  CNT_W  mismatching beats, saturates at all-ones
len_err  out  1  tlast position disagreed with cfg_len
first_err_beat  out  LEN_W  beat index (0-based) of first mismatch
first_err_dut  out  DATA_W  DUT data of first mismatching beat
first_err_exp  out  DATA_W  expected data of first mismatching beat

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, pass, err_count, len_err, first_err_*, and both treadys. PRNG state = 1.
- States:
  - IDLE -> RUN on cfg_start.
  - RUN -> DONE when the beat with index len-1 is accepted.
  - DONE -> RUN on cfg_start.
- On cfg_start:
  - Latch mode, len (0 -> 1) and seed; a seed of 0 is replaced by 1.
  - Clear err_count, len_err, first_err_*, pass and done; beat counter = 0.
  - busy rises the next cycle.
- Join handshake in RUN:
  - mode 0: a beat fires when s_dut_tvalid && s_exp_tvalid. s_dut_tready = s_exp_tvalid and s_exp_tready = s_dut_tvalid. Both readys are combinational within RUN and 0 outside it; the valids never depend on the readys.
  - mode 1: s_dut_tready = 1 in RUN and s_exp_tready = 0. A beat fires on s_dut_tvalid.
- PRNG:
  - 32-bit Galois LFSR, taps mask 0x80200003; right-shift and XOR the mask when the shifted-out lsb = 1.
  - For each beat, 32-bit lane i of expected = state XOR (i * 0x9E3779B9 mod 2^32).
  - The state steps once per fired beat. Beat 0 uses the seed itself.
- Compare:
  - A beat mismatches if any byte b with tkeep[b]=1 differs between DUT and expected.
  - Mismatching byte positions are evaluated combinationally; results register on the fire cycle (1-cycle latency to err_count and first_err_*).
  - On the first mismatch of a run, capture beat index, full DUT data and full expected data. Later mismatches do not overwrite the capture.
  - err_count increments per mismatching beat and holds at 2^CNT_W-1.
- Length check, evaluated on each fired beat:
  - tlast=1 on a beat other than len-1 sets len_err and ends the run (-> DONE).
  - tlast=0 on beat len-1 sets len_err.
- DONE:
  - Entered one cycle after the final fire, so the final compare result is included.
  - done=1, busy=0, pass = (err_count==0 && !len_err).
  - Status holds until the next cfg_start.
- Simultaneous events: cfg_start in RUN is ignored. cfg_start in the same cycle as the final fire is ignored.
- Reset in RUN: immediate return to IDLE. Status cleared; no partial result retained.
- Beat counter and index are LEN_W wide and do not wrap, because len ≤ 2^LEN_W-1.

Test Plan:
- DATA_W=64, mode 1, seed 0x00000001, len 4, DUT replays the same PRNG beats, tlast on beat 3 -> done, pass=1, err_count=0, len_err=0.
- Mode 0, len 3; expected beats 0x11..11/0x22..22/0x33..33; DUT beat 1 = 0x22..23 -> err_count=1, first_err_beat=1, first_err_dut=0x2222222222222223, first_err_exp=0x2222222222222222, pass=0.
- Mode 0, mismatch only in byte 7 with tkeep=0x7F -> err_count=0, pass=1. Repeat with tkeep=0xFF -> err_count=1.
- Mode 0, s_exp_tvalid toggling every other cycle and DUT valid random -> no beat consumed without the other; exactly len fires per stream; pass=1.
- len 4, tlast on beat 1 -> DONE after beat 1, len_err=1, pass=0. New run with tlast missing on beat 3 -> len_err=1.
- CNT_W=2, 5 mismatching beats -> err_count=3 (saturated). Reset asserted mid-run -> all status 0, state IDLE. Seed 0 -> same expected data as seed 1.
